conv_layer_tile_sched: RTL and testbench

//  Layer-level tile scheduler for conv_tile. Walks every (n,row,col,m) tile of one conv layer,

---
 rtl/conv_sched_pkg.sv | 39 +++
 rtl/conv_layer_tile_sched_if.sv | 54 +++++
 rtl/conv_tile_idx_cnt.sv | 66 ++++++
 rtl/conv_layer_tile_sched.sv | 139 +++++++++++++
 tb/tb_conv_layer_tile_sched.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and default geometry for the conv layer tile scheduler.
// Default tiling gives 2x2x1x2 = 8 tiles per layer.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ADV   = 3'd3,
    S_FIN   = 3'd4
  } sched_state_t;

  localparam int DEF_AW = 32;
  localparam int DEF_N  = 32;
  localparam int DEF_TN = 16;
  localparam int DEF_M  = 32;
  localparam int DEF_TM = 16;
  localparam int DEF_R  = 64;
  localparam int DEF_TR = 64;
  localparam int DEF_C  = 32;
  localparam int DEF_TC = 16;

  localparam int NT = DEF_N / DEF_TN;
  localparam int MT = DEF_M / DEF_TM;
  localparam int RT = DEF_R / DEF_TR;
  localparam int CT = DEF_C / DEF_TC;
  localparam int TILE_TOTAL = NT * MT * RT * CT;

  // A single-tile dimension still needs a 1-bit index register.
  function automatic int idx_w(input int cnt);
    return (cnt > 1) ? $clog2(cnt) : 1;
  endfunction

  localparam int NT_W = idx_w(NT);
  localparam int MT_W = idx_w(MT);
  localparam int RT_W = idx_w(RT);
  localparam int CT_W = idx_w(CT);

endpackage

// File: rtl/conv_layer_tile_sched_if.sv
// Host/conv_tile facing signals of the tile scheduler.
// CONV_SCHED_PERF_CNT_EN adds the perf_cycles/perf_tiles counters.
interface conv_layer_tile_sched_if #(
  parameter int AW = 32
);
  logic          layer_start;
  logic          layer_done;
  logic          busy;
  logic          conv_tile_start;
  logic          conv_tile_done;
  logic [AW-1:0] tile_base_n;
  logic [AW-1:0] tile_base_m;
  logic [AW-1:0] tile_base_row;
  logic [AW-1:0] tile_base_col;
`ifdef CONV_SCHED_PERF_CNT_EN
  logic [31:0]   perf_cycles;
  logic [15:0]   perf_tiles;
`endif

  modport master (
    input  layer_start,
    input  conv_tile_done,
    output layer_done,
    output busy,
    output conv_tile_start,
    output tile_base_n,
    output tile_base_m,
    output tile_base_row,
    output tile_base_col
`ifdef CONV_SCHED_PERF_CNT_EN
    ,
    output perf_cycles,
    output perf_tiles
`endif
  );

  modport slave (
    output layer_start,
    output conv_tile_done,
    input  layer_done,
    input  busy,
    input  conv_tile_start,
    input  tile_base_n,
    input  tile_base_m,
    input  tile_base_row,
    input  tile_base_col
`ifdef CONV_SCHED_PERF_CNT_EN
    ,
    input  perf_cycles,
    input  perf_tiles
`endif
  );

endinterface

// File: rtl/conv_tile_idx_cnt.sv
// Four-level nested wrap counter over (n,row,col,m) tile indices, m innermost.
module conv_tile_idx_cnt
  import conv_sched_pkg::*;
#(
  parameter int NT = 2,
  parameter int MT = 2,
  parameter int RT = 1,
  parameter int CT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    step,
  output logic [idx_w(NT)-1:0]    n_idx,
  output logic [idx_w(MT)-1:0]    m_idx,
  output logic [idx_w(RT)-1:0]    row_idx,
  output logic [idx_w(CT)-1:0]    col_idx,
  output logic                    last_tile
);

  localparam int NW = idx_w(NT);
  localparam int MW = idx_w(MT);
  localparam int RW = idx_w(RT);
  localparam int CW = idx_w(CT);

  localparam logic [NW-1:0] N_LAST = NW'(NT - 1);
  localparam logic [MW-1:0] M_LAST = MW'(MT - 1);
  localparam logic [RW-1:0] R_LAST = RW'(RT - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CT - 1);

  logic m_wrap, col_wrap, row_wrap, n_wrap;

  assign m_wrap    = (m_idx == M_LAST);
  assign col_wrap  = (col_idx == C_LAST);
  assign row_wrap  = (row_idx == R_LAST);
  assign n_wrap    = (n_idx == N_LAST);
  assign last_tile = m_wrap && col_wrap && row_wrap && n_wrap;

  // Each level advances only when every inner level wraps on the same step.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      n_idx   <= '0;
      m_idx   <= '0;
      row_idx <= '0;
      col_idx <= '0;
    end else if (step) begin
      if (!m_wrap) begin
        m_idx <= m_idx + MW'(1);
      end else begin
        m_idx <= '0;
        if (!col_wrap) begin
          col_idx <= col_idx + CW'(1);
        end else begin
          col_idx <= '0;
          if (!row_wrap) begin
            row_idx <= row_idx + RW'(1);
          end else begin
            row_idx <= '0;
            n_idx   <= n_wrap ? '0 : n_idx + NW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/conv_layer_tile_sched.sv
// Layer-level tile scheduler: issues one conv_tile_start per (n,row,col,m) tile and waits for done.
// Optional CONV_SCHED_PERF_CNT_EN adds busy-cycle and completed-tile counters.
module conv_layer_tile_sched
  import conv_sched_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int N  = DEF_N,
  parameter int TN = DEF_TN,
  parameter int M  = DEF_M,
  parameter int TM = DEF_TM,
  parameter int R  = DEF_R,
  parameter int TR = DEF_TR,
  parameter int C  = DEF_C,
  parameter int TC = DEF_TC
) (
  input  logic                     clk,
  input  logic                     rst,
  conv_layer_tile_sched_if.master  bus
);

  localparam int N_TILES = N / TN;
  localparam int M_TILES = M / TM;
  localparam int R_TILES = R / TR;
  localparam int C_TILES = C / TC;

  localparam int NW = idx_w(N_TILES);
  localparam int MW = idx_w(M_TILES);
  localparam int RW = idx_w(R_TILES);
  localparam int CW = idx_w(C_TILES);

  sched_state_t  state;
  logic [NW-1:0] n_idx;
  logic [MW-1:0] m_idx;
  logic [RW-1:0] row_idx;
  logic [CW-1:0] col_idx;
  logic          last_tile;
  logic          last_r;
  logic          start_accept;
  logic          tile_step;

  assign start_accept = (state == S_IDLE) && bus.layer_start;
  assign tile_step    = (state == S_WAIT) && bus.conv_tile_done;

  conv_tile_idx_cnt #(
    .NT(N_TILES),
    .MT(M_TILES),
    .RT(R_TILES),
    .CT(C_TILES)
  ) u_idx_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_accept),
    .step      (tile_step),
    .n_idx     (n_idx),
    .m_idx     (m_idx),
    .row_idx   (row_idx),
    .col_idx   (col_idx),
    .last_tile (last_tile)
  );

  // Indices advance on the accepted done, so in ADV they already name the next tile
  // and the bases can be registered from them in time for the following ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      last_r              <= 1'b0;
      bus.busy            <= 1'b0;
      bus.layer_done      <= 1'b0;
      bus.conv_tile_start <= 1'b0;
      bus.tile_base_n     <= '0;
      bus.tile_base_m     <= '0;
      bus.tile_base_row   <= '0;
      bus.tile_base_col   <= '0;
    end else begin
      bus.conv_tile_start <= 1'b0;
      bus.layer_done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.layer_start) begin
            state               <= S_ISSUE;
            bus.busy            <= 1'b1;
            bus.conv_tile_start <= 1'b1;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.conv_tile_done) begin
            state  <= S_ADV;
            last_r <= last_tile;
          end
        end
        S_ADV: begin
          bus.tile_base_n   <= AW'(n_idx) * AW'(TN);
          bus.tile_base_m   <= AW'(m_idx) * AW'(TM);
          bus.tile_base_row <= AW'(row_idx) * AW'(TR);
          bus.tile_base_col <= AW'(col_idx) * AW'(TC);
          if (last_r) begin
            state          <= S_FIN;
            bus.layer_done <= 1'b1;
          end else begin
            state               <= S_ISSUE;
            bus.conv_tile_start <= 1'b1;
          end
        end
        S_FIN: begin
          state             <= S_IDLE;
          bus.busy          <= 1'b0;
          bus.tile_base_n   <= '0;
          bus.tile_base_m   <= '0;
          bus.tile_base_row <= '0;
          bus.tile_base_col <= '0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CONV_SCHED_PERF_CNT_EN
  // Counters keep the last layer's values until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst || start_accept) begin
      bus.perf_cycles <= '0;
      bus.perf_tiles  <= '0;
    end else begin
      if (bus.busy && (bus.perf_cycles != '1)) begin
        bus.perf_cycles <= bus.perf_cycles + 32'd1;
      end
      if (tile_step) begin
        bus.perf_tiles <= bus.perf_tiles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_conv_layer_tile_sched.sv
// Randomized self-checking bench for conv_layer_tile_sched against a nested-loop tile model.
// Perf counters are checked when CONV_SCHED_PERF_CNT_EN is defined.
module tb_conv_layer_tile_sched;

  localparam int AW = 32;
  localparam int LN = 32, LTN = 16, LM = 32, LTM = 16, LR = 64, LTR = 64, LC = 32, LTC = 16;
  localparam int TILES = (LN / LTN) * (LM / LTM) * (LR / LTR) * (LC / LTC);

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_n[TILES], exp_m[TILES], exp_row[TILES], exp_col[TILES];
  int   bc;

  always #5 clk = ~clk;

  conv_layer_tile_sched_if #(.AW(AW)) bus0 ();
  conv_layer_tile_sched_if #(.AW(AW)) bus1 ();

  conv_layer_tile_sched #(.AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  conv_layer_tile_sched #(
    .AW(AW), .N(16), .TN(16), .M(16), .TM(16), .R(64), .TR(64), .C(16), .TC(16)
  ) dut_single (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkBases(input string tag, input int i);
    checkOutput({tag, "_n"},   64'(bus0.tile_base_n),   64'(exp_n[i]));
    checkOutput({tag, "_m"},   64'(bus0.tile_base_m),   64'(exp_m[i]));
    checkOutput({tag, "_row"}, 64'(bus0.tile_base_row), 64'(exp_row[i]));
    checkOutput({tag, "_col"}, 64'(bus0.tile_base_col), 64'(exp_col[i]));
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"},  64'(bus0.busy), 64'd0);
    checkOutput({tag, "_start"}, 64'(bus0.conv_tile_start), 64'd0);
    checkOutput({tag, "_done"},  64'(bus0.layer_done), 64'd0);
    checkOutput({tag, "_bases"}, 64'(bus0.tile_base_n | bus0.tile_base_m |
                                     bus0.tile_base_row | bus0.tile_base_col), 64'd0);
  endtask

  // Runs one layer on the default DUT; fixed_lat=0 picks random done latencies.
  task automatic applyStimulus(input int fixed_lat, input bit inject, input int rst_tile,
                               output int busy_cycles);
    int lat;
    busy_cycles = 0;
    bus0.layer_start = 1'b1;
    tick();
    bus0.layer_start = 1'b0;
    for (int i = 0; i < TILES; i++) begin
      checkOutput("tile_start", 64'(bus0.conv_tile_start), 64'd1);
      checkOutput("busy_issue", 64'(bus0.busy), 64'd1);
      checkOutput("done_issue", 64'(bus0.layer_done), 64'd0);
      checkBases("base_issue", i);
      lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
      busy_cycles += lat + 2;
      if (inject && i == 3) begin
        bus0.conv_tile_done = 1'b1;
        bus0.layer_start    = 1'b1;
      end
      tick();
      bus0.conv_tile_done = 1'b0;
      bus0.layer_start    = 1'b0;
      for (int j = 1; j < lat; j++) begin
        checkOutput("start_wait", 64'(bus0.conv_tile_start), 64'd0);
        checkOutput("busy_wait", 64'(bus0.busy), 64'd1);
        tick();
      end
      checkOutput("start_donecyc", 64'(bus0.conv_tile_start), 64'd0);
      checkBases("base_stable", i);
      if (i == rst_tile) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkIdleOutputs("rst_mid");
        tick();
        checkIdleOutputs("rst_after");
        return;
      end
      bus0.conv_tile_done = 1'b1;
      tick();
      bus0.conv_tile_done = 1'b0;
      checkOutput("start_adv", 64'(bus0.conv_tile_start), 64'd0);
      checkOutput("done_adv", 64'(bus0.layer_done), 64'd0);
      tick();
    end
    busy_cycles += 1;
    checkOutput("layer_done", 64'(bus0.layer_done), 64'd1);
    checkOutput("busy_fin", 64'(bus0.busy), 64'd1);
    checkOutput("start_fin", 64'(bus0.conv_tile_start), 64'd0);
    tick();
    checkIdleOutputs("post_layer");
  endtask

  task automatic checkPerf(input int exp_cycles, input int exp_tiles);
`ifdef CONV_SCHED_PERF_CNT_EN
    checkOutput("perf_cycles", 64'(bus0.perf_cycles), 64'(exp_cycles));
    checkOutput("perf_tiles",  64'(bus0.perf_tiles),  64'(exp_tiles));
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k = 0;
    for (int n = 0; n < LN; n += LTN)
      for (int r = 0; r < LR; r += LTR)
        for (int c = 0; c < LC; c += LTC)
          for (int m = 0; m < LM; m += LTM) begin
            exp_n[k] = n; exp_row[k] = r; exp_col[k] = c; exp_m[k] = m;
            k++;
          end

    rst = 1'b1;
    bus0.layer_start = 1'b0; bus0.conv_tile_done = 1'b0;
    bus1.layer_start = 1'b0; bus1.conv_tile_done = 1'b0;
    repeat (3) tick();
    checkIdleOutputs("reset");
    checkPerf(0, 0);
    rst = 1'b0;
    tick();
    bus0.conv_tile_done = 1'b1;
    tick();
    bus0.conv_tile_done = 1'b0;
    checkIdleOutputs("idle_done_ignored");

    applyStimulus(5, 1'b0, -1, bc);
    checkOutput("busy_cycles_lat5", 64'(bc), 64'd57);
    checkPerf(bc, TILES);

    applyStimulus(0, 1'b1, -1, bc);
    checkPerf(bc, TILES);

    applyStimulus(0, 1'b0, 4, bc);
    checkPerf(0, 0);
    applyStimulus(0, 1'b0, -1, bc);
    checkPerf(bc, TILES);

    for (int l = 0; l < 3; l++) begin
      applyStimulus(0, l[0], -1, bc);
      checkPerf(bc, TILES);
    end

    bus1.layer_start = 1'b1;
    tick();
    bus1.layer_start = 1'b0;
    checkOutput("single_start", 64'(bus1.conv_tile_start), 64'd1);
    checkOutput("single_bases", 64'(bus1.tile_base_n | bus1.tile_base_m |
                                    bus1.tile_base_row | bus1.tile_base_col), 64'd0);
    tick();
    checkOutput("single_wait", 64'(bus1.conv_tile_start), 64'd0);
    tick();
    bus1.conv_tile_done = 1'b1;
    tick();
    bus1.conv_tile_done = 1'b0;
    checkOutput("single_adv_start", 64'(bus1.conv_tile_start), 64'd0);
    checkOutput("single_adv_done", 64'(bus1.layer_done), 64'd0);
    tick();
    checkOutput("single_layer_done", 64'(bus1.layer_done), 64'd1);
    checkOutput("single_fin_start", 64'(bus1.conv_tile_start), 64'd0);
    tick();
    checkOutput("single_busy_off", 64'(bus1.busy), 64'd0);
    checkOutput("single_done_off", 64'(bus1.layer_done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
